// File: rtl/iserdes_bitslip_ctrl.sv
// Word-alignment training controller for one ISERDESE2 lane.
// Waits for the deserialised word to settle, compares it against a training
// pattern and issues BITSLIP pulses until the pattern is seen on MATCH_COUNT
// consecutive divclk cycles (done) or the slip budget runs out (fail).
`timescale 1ns/1ps
module iserdes_bitslip_ctrl #(
    parameter int DW            = 4,
    parameter int SETTLE_CYCLES = 3,
    parameter int MATCH_COUNT   = 8,
    parameter int MAX_SLIPS     = 7
) (
    input  logic                           divclk,
    input  logic                           resetn,
    input  logic                           start,
    input  logic [DW-1:0]                  train_pattern,
    input  logic [DW-1:0]                  q,
    input  logic                           monitor_en,
    output logic                           bitslip,
    output logic                           busy,
    output logic                           done,
    output logic                           fail,
    output logic                           lock_lost,
    output logic [$clog2(MAX_SLIPS+1)-1:0] slip_count
);
    localparam int SCW = $clog2(MAX_SLIPS+1);
    localparam int STW = $clog2(SETTLE_CYCLES+1);
    localparam int MCW = $clog2(MATCH_COUNT+1);
    localparam logic [STW-1:0] SETTLE_LOAD = STW'(SETTLE_CYCLES-1);
    localparam logic [MCW-1:0] MATCH_LAST  = MCW'(MATCH_COUNT-1);
    localparam logic [SCW-1:0] SLIP_MAX    = SCW'(MAX_SLIPS);

    typedef enum logic [2:0] {
        IDLE, SETTLE, CHECK, SLIP, DONE, FAIL
    } state_t;

    state_t          state, state_n;
    logic [STW-1:0]  settle_cnt, settle_n;
    logic [MCW-1:0]  match_cnt, match_n;
    logic [SCW-1:0]  slip_n;
    logic            bitslip_n, busy_n, done_n, fail_n, lost_n;

    // State and every output are registered; reset clears all immediately.
    always_ff @(posedge divclk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            settle_cnt <= '0;
            match_cnt  <= '0;
            slip_count <= '0;
            bitslip    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            lock_lost  <= 1'b0;
        end else begin
            state      <= state_n;
            settle_cnt <= settle_n;
            match_cnt  <= match_n;
            slip_count <= slip_n;
            bitslip    <= bitslip_n;
            busy       <= busy_n;
            done       <= done_n;
            fail       <= fail_n;
            lock_lost  <= lost_n;
        end
    end

    // Next-state and next-output decode; outputs are derived from the next
    // state so they line up with the state register.
    always_comb begin
        state_n   = state;
        settle_n  = settle_cnt;
        match_n   = match_cnt;
        slip_n    = slip_count;
        bitslip_n = 1'b0;
        done_n    = done;
        fail_n    = fail;
        lost_n    = lock_lost;
        case (state)
            IDLE, DONE, FAIL: begin
                // Post-lock monitoring only; no automatic retrain.
                if (state == DONE && monitor_en && q != train_pattern)
                    lost_n = 1'b1;
                if (start) begin
                    state_n  = SETTLE;
                    settle_n = SETTLE_LOAD;
                    slip_n   = '0;
                    done_n   = 1'b0;
                    fail_n   = 1'b0;
                    lost_n   = 1'b0;
                end
            end
            SETTLE: begin
                if (settle_cnt == '0) begin
                    state_n = CHECK;
                    match_n = '0;
                end else begin
                    settle_n = settle_cnt - 1'b1;
                end
            end
            CHECK: begin
                if (q == train_pattern) begin
                    if (match_cnt == MATCH_LAST) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        match_n = match_cnt + 1'b1;
                    end
                end else begin
                    match_n = '0;
                    if (slip_count == SLIP_MAX) begin
                        state_n = FAIL;
                        fail_n  = 1'b1;
                    end else begin
                        state_n   = SLIP;
                        bitslip_n = 1'b1;
                    end
                end
            end
            SLIP: begin
                // The slip counts once its pulse has been issued.
                slip_n   = slip_count + 1'b1;
                settle_n = SETTLE_LOAD;
                state_n  = SETTLE;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n == SETTLE) || (state_n == CHECK) || (state_n == SLIP);
    end
endmodule

// File: tb/tb_iserdes_bitslip_ctrl.sv
// Self-checking bench for iserdes_bitslip_ctrl: an ISERDES model that rotates
// the word once per bitslip drives q, and an event-level predictor builds the
// expected output timeline of each training run.
`timescale 1ns/1ps
module tb_iserdes_bitslip_ctrl;
    localparam int DW = 4, SETTLE = 3, MATCH = 8, MAXS = 7, SCW = 3, HMAX = 256;

    logic          divclk = 1'b0, resetn = 1'b0, start = 1'b0, monitor_en = 1'b0;
    logic [DW-1:0] train_pattern = '0, q = '0;
    logic          bitslip, busy, done, fail, lock_lost;
    logic [SCW-1:0] slip_count;

    iserdes_bitslip_ctrl #(.DW(DW), .SETTLE_CYCLES(SETTLE), .MATCH_COUNT(MATCH), .MAX_SLIPS(MAXS)) dut (
        .divclk(divclk), .resetn(resetn), .start(start), .train_pattern(train_pattern),
        .q(q), .monitor_en(monitor_en), .bitslip(bitslip), .busy(busy), .done(done),
        .fail(fail), .lock_lost(lock_lost), .slip_count(slip_count)
    );

    always #5 divclk = ~divclk;

    int vecs = 0, errs = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scenario description (indices are edges relative to the start edge).
    logic [DW-1:0] pat_s, nev_val;
    int            off;
    bit            never, fixed_q, mon;
    bit            bad[HMAX];
    logic [DW-1:0] noise[HMAX];
    // Expected {lock_lost, fail, done, busy, bitslip, slip_count} after each edge.
    logic [7:0]    exp_o[HMAX];
    int            end_r;

    function automatic logic [DW-1:0] rotl(input logic [DW-1:0] w, input int n);
        logic [DW-1:0] o;
        o = '0;
        for (int i = 0; i < DW; i++) o[(i + n) % DW] = w[i];
        return o;
    endfunction

    // Word seen at relative edge r after s slips: the lane starts 'off' slips
    // away from alignment unless the scenario pins q.
    function automatic logic [DW-1:0] q_at(input int r, input int s);
        if (r < HMAX && bad[r]) return pat_s ^ noise[r];
        if (never)              return nev_val;
        if (fixed_q)            return pat_s;
        return rotl(pat_s, (off - (s % DW) + DW) % DW);
    endfunction

    function automatic void put(input int r, input bit b, input bit bs, input int s);
        if (r < HMAX) exp_o[r] = {3'b000, b, bs, 3'(s)};
    endfunction

    // Walk a training run as settle windows, match runs and slips.
    function automatic void predict();
        int r = 0, s = 0, run;
        bit fin = 0, ok = 0, slipped, lost = 0;
        for (int t = 0; t < HMAX; t++) exp_o[t] = '0;
        while (!fin && r < HMAX - 16) begin
            for (int i = 0; i < SETTLE; i++) begin put(r, 1, 0, s); r++; end
            run = 0;
            slipped = 0;
            while (!fin && !slipped && r < HMAX - 16) begin
                put(r, 1, 0, s);
                r++;
                if (q_at(r, s) == pat_s) begin
                    run++;
                    if (run == MATCH) begin fin = 1; ok = 1; end
                end else if (s == MAXS) begin
                    fin = 1;
                end else begin
                    put(r, 1, 1, s);
                    r++;
                    s++;
                    slipped = 1;
                end
            end
        end
        end_r = r;
        for (int t = r; t < HMAX; t++) begin
            if (ok && t > r && mon && q_at(t, s) != pat_s) lost = 1;
            exp_o[t] = {lost, !ok, ok, 1'b0, 1'b0, 3'(s)};
        end
    endfunction

    task automatic set_scn(input logic [DW-1:0] p, input int o, input bit nv, input bit fx, input bit m);
        pat_s = p; off = o; never = nv; fixed_q = fx; mon = m; nev_val = ~p;
        for (int t = 0; t < HMAX; t++) begin bad[t] = 0; noise[t] = 4'hF; end
    endtask

    // Drive one training run; 'extra' is a relative edge for a second start
    // pulse, applied only where the controller should be busy.
    task automatic run_case(input string name, input int extra);
        int slips = 0;
        predict();
        @(negedge divclk);
        train_pattern = pat_s;
        monitor_en    = mon;
        start         = 1'b1;
        q             = q_at(0, 0);
        for (int r = 0; r <= end_r + 6; r++) begin
            @(negedge divclk);
            chk($sformatf("%s r%0d", name, r),
                {24'd0, lock_lost, fail, done, busy, bitslip, slip_count}, {24'd0, exp_o[r]});
            start = (r + 1 == extra) && exp_o[r][4];
            q     = q_at(r + 1, slips);
            if (bitslip) slips++;
        end
        start = 1'b0;
    endtask

    initial begin
        bit found;
        repeat (3) @(negedge divclk);
        chk("reset", {26'd0, lock_lost, fail, done, busy, bitslip, slip_count}, 32'd0);
        resetn = 1'b1;

        // Aligned from the start: done 12 edges after start, no slips.
        set_scn(4'hA, 0, 0, 0, 0);
        run_case("aligned", 2);
        // Lane two slips away from alignment.
        set_scn(4'h1, 2, 0, 0, 0);
        run_case("offset2", 5);
        // Never matches: full slip budget, then fail.
        set_scn(4'hA, 0, 1, 0, 0);
        nev_val = 4'h0;
        run_case("never", 7);
        // Five matches, one mismatch, then steady match.
        set_scn(4'hA, 0, 0, 1, 0);
        bad[9] = 1;
        run_case("intermit", 0);
        // Lock, then a single 4'h5 word with monitoring enabled.
        set_scn(4'hA, 0, 0, 1, 1);
        bad[14] = 1;
        noise[14] = 4'hF;
        run_case("locklost", 3);
        // Restart from DONE with lock_lost set clears and retrains.
        set_scn(4'h3, 1, 0, 0, 1);
        run_case("restart", 4);

        // Randomised runs.
        for (int n = 0; n < 14; n++) begin
            set_scn(4'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 4) == 0,
                    $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
            for (int t = 0; t < HMAX; t++) begin
                bad[t]   = ($urandom_range(0, 9) == 0);
                noise[t] = 4'($urandom_range(1, 15));
            end
            run_case($sformatf("rand%0d", n), $urandom_range(1, 12));
        end

        // Asynchronous reset during a SLIP cycle.
        set_scn(4'hA, 0, 1, 0, 0);
        @(negedge divclk);
        train_pattern = 4'hA;
        monitor_en    = 1'b0;
        q             = 4'h0;
        start         = 1'b1;
        @(negedge divclk);
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge divclk);
            if (bitslip && slip_count == 3'd2) found = 1;
        end
        chk("rst_wait_slip", {31'd0, found}, 32'd1);
        #2 resetn = 1'b0;
        #1 chk("rst_async", {26'd0, lock_lost, fail, done, busy, bitslip, slip_count}, 32'd0);
        @(negedge divclk);
        resetn = 1'b1;
        set_scn(4'h6, 3, 0, 0, 0);
        run_case("after_rst", 2);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
